// File: rtl/gps_corr_pkg.sv
// Shared types and helpers for the C/A code correlator: default accumulator width,
// saturation limits, integration state encoding and the 1-bit BPSK product.
package gps_corr_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int SAT_MAX   = (1 << (ACC_W_DEF - 1)) - 1;
  localparam int SAT_MIN   = -SAT_MAX;

  typedef enum logic {
    ST_IDLE,
    ST_INTEG
  } corr_state_t;

  // Sign bits encode 0 = +1, 1 = -1, so equal bits multiply to +1.
  function automatic logic signed [1:0] bpsk_prod(input logic a, input logic b);
    return (a == b) ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/corr_acc.sv
// One correlation arm: loads or adds a +/-1 product, clamping symmetrically at
// +/-(2^(ACC_W-1)-1). Once clamped the value holds until the next load.
module corr_acc
  import gps_corr_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [1:0]       prod,
  output logic signed [ACC_W-1:0] acc
);

  localparam logic signed [ACC_W-1:0] MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN   = -MAX;
  localparam logic signed [ACC_W:0]   MAX_X = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   MIN_X = -MAX_X;

  logic               sat_hit;
  logic signed [ACC_W:0] sum;

  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W-1){prod[1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sat_hit <= 1'b0;
    end else if (en) begin
      if (load) begin
        acc     <= {{(ACC_W-2){prod[1]}}, prod};
        sat_hit <= 1'b0;
      end else if (!sat_hit) begin
        if (sum > MAX_X) begin
          acc     <= MAX;
          sat_hit <= 1'b1;
        end else if (sum < MIN_X) begin
          acc     <= MIN;
          sat_hit <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/shift_reg.sv
// Serial-in parallel-out shift register; q[0] holds the most recently shifted bit.
module shift_reg #(
  parameter int bit_count = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 d,
  output logic [bit_count-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[bit_count-2:0], d};
    end
  end

endmodule

// File: rtl/ca_code_correlator.sv
// Early/prompt/late correlator for 1-bit IF samples against the local C/A replica,
// integrated over N_EPOCH code periods and handed off through a valid/ready dump register.
//
// state    | meaning
// ST_IDLE  | not armed; partial period after reset is discarded at the first epoch
// ST_INTEG | integrating; epoch_cnt counts code periods in the current dump
module ca_code_correlator
  import gps_corr_pkg::*;
#(
  parameter int SPACING = 2,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_EPOCH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    sample_in,
  input  logic                    code_early,
  input  logic                    epoch,
  input  logic                    dump_ready,
  output logic                    dump_valid,
  output logic signed [ACC_W-1:0] e_acc,
  output logic signed [ACC_W-1:0] p_acc,
  output logic signed [ACC_W-1:0] l_acc,
  output logic                    overrun
);

  localparam logic [7:0] N_EP = 8'(N_EPOCH);

  logic [2*SPACING-1:0]   taps;
  logic                   code_prompt;
  logic                   code_late;
  logic                   unused_taps;
  logic signed [1:0]      prod_e;
  logic signed [1:0]      prod_p;
  logic signed [1:0]      prod_l;
  logic signed [ACC_W-1:0] acc_e;
  logic signed [ACC_W-1:0] acc_p;
  logic signed [ACC_W-1:0] acc_l;

  corr_state_t state, state_nxt;
  logic [7:0]  epoch_cnt, epoch_cnt_nxt;
  logic        load;
  logic        dump;

  shift_reg #(.bit_count(2*SPACING)) u_dly (
    .clk (clk),
    .rst (rst),
    .en  (sample_valid),
    .d   (code_early),
    .q   (taps)
  );

  assign code_prompt = taps[SPACING-1];
  assign code_late   = taps[2*SPACING-1];
  assign unused_taps = ^taps;

  assign prod_e = bpsk_prod(sample_in, code_early);
  assign prod_p = bpsk_prod(sample_in, code_prompt);
  assign prod_l = bpsk_prod(sample_in, code_late);

  corr_acc #(.ACC_W(ACC_W)) u_acc_e (
    .clk(clk), .rst(rst), .en(sample_valid), .load(load), .prod(prod_e), .acc(acc_e)
  );
  corr_acc #(.ACC_W(ACC_W)) u_acc_p (
    .clk(clk), .rst(rst), .en(sample_valid), .load(load), .prod(prod_p), .acc(acc_p)
  );
  corr_acc #(.ACC_W(ACC_W)) u_acc_l (
    .clk(clk), .rst(rst), .en(sample_valid), .load(load), .prod(prod_l), .acc(acc_l)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      epoch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      epoch_cnt <= epoch_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    epoch_cnt_nxt = epoch_cnt;
    load          = 1'b0;
    dump          = 1'b0;
    if (sample_valid && epoch) begin
      load          = 1'b1;
      epoch_cnt_nxt = 8'd1;
      state_nxt     = ST_INTEG;
      if (state == ST_INTEG) begin
        if (epoch_cnt < N_EP) begin
          load          = 1'b0;
          epoch_cnt_nxt = epoch_cnt + 8'd1;
        end else begin
          dump = 1'b1;
        end
      end
    end
  end

  // Dump captures the sums as they stood before the epoch sample, which starts the next integration.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_valid <= 1'b0;
      e_acc      <= '0;
      p_acc      <= '0;
      l_acc      <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= dump && dump_valid && !dump_ready;
      if (dump) begin
        dump_valid <= 1'b1;
        e_acc      <= acc_e;
        p_acc      <= acc_p;
        l_acc      <= acc_l;
      end else if (dump_valid && dump_ready) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ca_code_correlator.sv
// Bench for ca_code_correlator: two configurations share one stimulus stream; a
// behavioural model fills a scoreboard that is drained on every accepted dump.
module tb_ca_code_correlator;

  typedef struct {
    int e;
    int p;
    int l;
  } dump_t;

  logic clk = 1'b0;
  logic rst, sample_valid, sample_in, code_early, epoch, dump_ready;
  logic dv0, ovr0, dv1, ovr1;
  logic signed [15:0] e0, p0, l0;
  logic signed [7:0]  e1, p1, l1;

  always #5 clk = ~clk;

  ca_code_correlator #(.SPACING(2), .ACC_W(16), .N_EPOCH(1)) dut0 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .code_early(code_early), .epoch(epoch), .dump_ready(dump_ready),
    .dump_valid(dv0), .e_acc(e0), .p_acc(p0), .l_acc(l0), .overrun(ovr0)
  );

  ca_code_correlator #(.SPACING(1), .ACC_W(8), .N_EPOCH(4)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .code_early(code_early), .epoch(epoch), .dump_ready(dump_ready),
    .dump_valid(dv1), .e_acc(e1), .p_acc(p1), .l_acc(l1), .overrun(ovr1)
  );

  int total = 0;
  int bad   = 0;
  bit ca[1023];
  logic [10:1] g1, g2;

  int spk[2] = '{2, 1};
  int nk[2]  = '{1, 4};
  int mx[2]  = '{32767, 127};

  bit    hist[$];
  dump_t sbq0[$];
  dump_t sbq1[$];
  int    m_acc[2][3];
  bit    m_sat[2][3];
  bit    m_armed[2];
  bit    m_pend[2];
  bit    m_ovr[2];
  int    m_cnt[2];
  int    last_e[2];
  int    n_ovr0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int prod(input bit a, input bit b);
    return (a == b) ? 1 : -1;
  endfunction

  function automatic bit tap(input int lag);
    if (hist.size() >= lag) return hist[hist.size() - lag];
    return 1'b0;
  endfunction

  task automatic pop_chk(input int k, input bit dv, input int e, input int p, input int l);
    dump_t d;
    int sz;
    if (dv && dump_ready) begin
      sz = (k == 0) ? sbq0.size() : sbq1.size();
      chk($sformatf("sb_avail%0d", k), sz, 1);
      if (sz > 0) begin
        if (k == 0) d = sbq0.pop_front();
        else        d = sbq1.pop_front();
        chk($sformatf("e_acc%0d", k), e, d.e);
        chk($sformatf("p_acc%0d", k), p, d.p);
        chk($sformatf("l_acc%0d", k), l, d.l);
        last_e[k] = e;
      end
    end
  endtask

  task automatic model_edge();
    int pr[3];
    int v;
    bit dev;
    bit acc_ok;
    dump_t d;
    if (rst) begin
      hist.delete();
      sbq0.delete();
      sbq1.delete();
      for (int k = 0; k < 2; k++) begin
        m_armed[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; m_cnt[k] = 0;
        for (int j = 0; j < 3; j++) begin m_acc[k][j] = 0; m_sat[k][j] = 0; end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        dev = 0;
        acc_ok = m_pend[k] && dump_ready;
        m_ovr[k] = 0;
        if (sample_valid) begin
          pr[0] = prod(sample_in, code_early);
          pr[1] = prod(sample_in, tap(spk[k]));
          pr[2] = prod(sample_in, tap(2 * spk[k]));
          if (epoch && (!m_armed[k] || m_cnt[k] == nk[k])) begin
            if (m_armed[k]) begin
              dev = 1;
              d.e = m_acc[k][0]; d.p = m_acc[k][1]; d.l = m_acc[k][2];
            end
            m_armed[k] = 1;
            m_cnt[k] = 1;
            for (int j = 0; j < 3; j++) begin m_acc[k][j] = pr[j]; m_sat[k][j] = 0; end
          end else begin
            if (epoch) m_cnt[k]++;
            for (int j = 0; j < 3; j++) begin
              if (!m_sat[k][j]) begin
                v = m_acc[k][j] + pr[j];
                if (v > mx[k])       begin m_acc[k][j] = mx[k];  m_sat[k][j] = 1; end
                else if (v < -mx[k]) begin m_acc[k][j] = -mx[k]; m_sat[k][j] = 1; end
                else m_acc[k][j] = v;
              end
            end
          end
        end
        if (dev) begin
          if (m_pend[k] && !dump_ready) begin
            m_ovr[k] = 1;
            if (k == 0) void'(sbq0.pop_back());
            else        void'(sbq1.pop_back());
          end
          m_pend[k] = 1;
          if (k == 0) sbq0.push_back(d);
          else        sbq1.push_back(d);
        end else if (acc_ok) begin
          m_pend[k] = 0;
        end
      end
      if (sample_valid) begin
        hist.push_back(code_early);
        if (hist.size() > 8) void'(hist.pop_front());
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input bit c, input bit ep, input bit rdy);
    rst = r; sample_valid = v; sample_in = s; code_early = c; epoch = ep; dump_ready = rdy;
    #1;
    if (!r) begin
      pop_chk(0, dv0, int'(e0), int'(p0), int'(l0));
      pop_chk(1, dv1, int'(e1), int'(p1), int'(l1));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("dump_valid0", int'(dv0), int'(m_pend[0]));
    chk("overrun0", int'(ovr0), int'(m_ovr[0]));
    chk("dump_valid1", int'(dv1), int'(m_pend[1]));
    chk("overrun1", int'(ovr1), int'(m_ovr[1]));
    if (ovr0) n_ovr0++;
    @(negedge clk);
  endtask

  // mode: 0 sample = code, 1 sample = ~code, 2 random sample
  task automatic run_period(input int len, input int mode, input bit rdy_ep, input bit rdy_rest, input bit gaps);
    int i;
    bit v, c, s;
    i = 0;
    while (i < len) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        c = ca[i];
        case (mode)
          0:       s = c;
          1:       s = ~c;
          default: s = 1'($urandom_range(0, 1));
        endcase
        cyc(1'b0, 1'b1, s, c, (i == 0), (i == 0) ? rdy_ep : rdy_rest);
        i++;
      end else begin
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rdy_rest);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    g1 = '1;
    g2 = '1;
    for (int i = 0; i < 1023; i++) begin
      ca[i] = g1[10] ^ g2[2] ^ g2[6];
      g1 = {g1[9:1], g1[3] ^ g1[10]};
      g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    end

    // reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_e0", int'(e0), 0);
    chk("rst_p0", int'(p0), 0);
    chk("rst_l0", int'(l0), 0);
    chk("rst_e1", int'(e1), 0);
    chk("rst_p1", int'(p1), 0);
    chk("rst_l1", int'(l1), 0);

    // matching samples: full-scale positive, narrow config saturates
    for (int n = 0; n < 5; n++) run_period(1023, 0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("match_e0", last_e[0], 1023);
    chk("match_e1_sat", last_e[1], 127);

    // inverted samples after reset: full-scale negative, clamp at -127 not -128
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) run_period(1023, 1, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("mismatch_e0", last_e[0], -1023);
    chk("mismatch_e1_sat", last_e[1], -127);

    // random samples, N_EPOCH = 4 on the narrow config
    for (int n = 0; n < 5; n++) run_period(1023, 2, 1'b1, 1'b1, 1'b0);

    // overwrite while not ready, then accept coinciding with a new dump
    n_ovr0 = 0;
    run_period(40, 2, 1'b1, 1'b0, 1'b0);
    run_period(40, 2, 1'b0, 1'b0, 1'b0);
    run_period(40, 2, 1'b1, 1'b0, 1'b0);
    run_period(40, 2, 1'b1, 1'b1, 1'b0);
    chk("overrun_count0", n_ovr0, 1);

    // gapped sample_valid with reset mid-integration
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) run_period(1023, 2, 1'b1, 1'b1, 1'b1);
    run_period(500, 2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_clears_valid0", int'(dv0), 0);
    run_period(40, 2, 1'b0, 1'b0, 1'b1);
    chk("no_dump_after_rst0", int'(dv0), 0);
    for (int n = 0; n < 2; n++) run_period(1023, 2, 1'b1, 1'b1, 1'b1);
    run_period(20, 2, 1'b1, 1'b1, 1'b0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
